lsu_port_arbiter: RTL and testbench
===================================

// Module: lsu_port_arbiter
// PURPOSE
// - Shares the single data-memory/IO load-store unit between two requesters:
//   port 0 is the core data path and port 1 is the debug/DMA loader.
// - Each port uses a req/gnt handshake. Arbitration is round-robin with a bounded burst.
// - Drives the LSU addr/st_data/st_en inputs and returns ld_data with a 1-cycle read latency.
// - Parks the LSU bus at a harmless address when idle, because the LSU writes IO registers on an address match alone.
// PARAMETERS
// - MAX_BURST  4      max back-to-back accepted transactions per owner while the other port waits (>=1)
// - PARK_ADDR  32'h0  LSU address driven while no transaction is accepted (must be a data-memory address)
// PORTS
// - clk_i        in   1   clock, all state on rising edge
// - rst_i        in   1   asynchronous, active-high reset
// - p_req_i      in   2   per-port request, held until granted
// - p_we_i       in   2   per-port write (1) / read (0)
// - p_addr_i     in   2x32 per-port byte address
// - p_wdata_i    in   2x32 per-port store data
// - p_gnt_o      out  2   per-port grant, combinational; accept = req & gnt
// - p_rvalid_o   out  2   per-port read data valid, 1 cycle after an accepted read
// - p_err_o      out  2   per-port misaligned-access error, 1 cycle after acceptance
// - p_rdata_o    out  32  read data, shared by both ports; qualify with p_rvalid_o
// - m_addr_o     out  32  to LSU addr
// - m_st_data_o  out  32  to LSU st_data
// - m_st_en_o    out  1   to LSU st_en
// - m_ld_data_i  in   32  from LSU ld_data (registered inside the LSU)
// BEHAVIOUR
// - Reset (async, while rst_i=1):
//   - all outputs are 0, except m_addr_o=PARK_ADDR;
//   - state: owner=NONE, last=P1 (so P0 wins the first tie), burst_cnt=0.
//   - Reset mid-transaction drops any pending rvalid/err. No pulse appears after reset releases.
// - State machine on owner: NONE / P0 / P1. Grant is a combinational function of the state and p_req_i:
//   - NONE: grant the sole requester. If both request, grant the port != last.
//   - Pk, and k still requests:
//     - keep Pk while burst_cnt<MAX_BURST or the other port is idle;
//     - otherwise grant the other port.
//   - Pk, and k drops its request: grant the other port if it requests, else NONE.
// - At most one p_gnt_o bit is high. At most one transaction is accepted per cycle.
// - On an accepted transaction: owner<=granted port, last<=granted port.
//   - burst_cnt <= (same owner as the previous cycle) ? sat(burst_cnt+1) : 1.
//   - burst_cnt saturates at MAX_BURST.
// - Idle cycle (no accept): owner<=NONE, burst_cnt<=0.
// - Accepted and aligned (addr[1:0]==0):
//   - m_addr_o=p_addr_i[k], m_st_data_o=p_wdata_i[k], m_st_en_o=p_we_i[k], all in the same cycle.
//   - For a read, p_rvalid_o[k]=1 in the next cycle, with p_rdata_o=m_ld_data_i.
// - Accepted and misaligned: the LSU is not driven (park values, st_en=0). p_err_o[k]=1 in the next cycle, with no rvalid.
// - No accept: m_addr_o=PARK_ADDR, m_st_data_o=0, m_st_en_o=0.
// - Writes have no response beyond the grant.
// - A read accepted in cycle N and a new accept in cycle N+1 are legal (fully pipelined, 1/cycle).
// - Both ports requesting continuously with MAX_BURST=B: the grant pattern is B of P0, then B of P1, repeating.
// - MAX_BURST=1 degenerates to strict alternation under contention.
// STRUCTURE
// - Package lsu_arb_pkg:
//   - owner_e enum {OWN_NONE, OWN_P0, OWN_P1};
//   - default PARK_ADDR;
//   - IO address constants: SW 9FF, LCD 8A0, LEDG 890, LEDR 880, HEX0..7 800..870, step 10h.
// - One sub-module, rr_pick2: combinational 2-way round-robin picker (req[1:0], last -> gnt[1:0]).
// - The top level holds the owner/last/burst_cnt registers and the response pipeline registers.
// TESTING
// - Reset: pulse rst_i mid-read (P0 read accepted, reset next edge) -> p_rvalid_o stays 0, m_addr_o=0, gnt=0.
// - Single read: P0 read addr 0x10 -> gnt[0] same cycle, m_st_en_o=0.
//   Next cycle p_rvalid_o=2'b01 and p_rdata_o equals the LSU word at 0x10.
// - Contention, MAX_BURST=4: both ports request continuously from reset -> grants P0 x4, P1 x4, P0 x4.
//   Never both gnt bits in one cycle.
// - Write pass-through: P1 write addr 0x800, data 0x3F -> m_addr_o=0x800, m_st_data_o=0x3F, m_st_en_o=1 for exactly one cycle.
//   m_addr_o returns to PARK_ADDR when idle.
// - Misaligned: P0 read addr 0x13 -> gnt[0]=1, m_addr_o stays PARK_ADDR.
//   Next cycle p_err_o=2'b01, p_rvalid_o=0.
// - Early release: P0 owner at burst_cnt=2 drops req while P1 requests -> P1 granted in the same cycle, burst_cnt=1.

Source files
------------

// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the LSU port arbiter: owner encoding, default
// park address and the memory-mapped IO register map the LSU decodes.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  // Parking must land in data memory: the LSU writes IO registers on address match alone.
  localparam logic [31:0] PARK_ADDR_DEFAULT = 32'h0000_0000;

  localparam logic [31:0] IO_SW       = 32'h0000_09FF;
  localparam logic [31:0] IO_LCD      = 32'h0000_08A0;
  localparam logic [31:0] IO_LEDG     = 32'h0000_0890;
  localparam logic [31:0] IO_LEDR     = 32'h0000_0880;
  localparam logic [31:0] IO_HEX0     = 32'h0000_0800;
  localparam logic [31:0] IO_HEX_STEP = 32'h0000_0010;

  // HEX0..HEX7 sit at 0x800..0x870 in 0x10 steps.
  function automatic logic [31:0] io_hex_addr(input logic [2:0] idx);
    return IO_HEX0 + {25'd0, idx, 4'd0};
  endfunction

endpackage

// File: rtl/lsu_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: a sole requester wins, and on a tie
// the port that was not served last wins.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,   // 0 = P0 served last, 1 = P1 served last
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/lsu_port_arbiter.sv
// Shares one load-store unit between the core data path (P0) and the
// debug/DMA loader (P1): round-robin with bounded bursts, 1-cycle read response.
module lsu_port_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int unsigned  MAX_BURST = 4,
  parameter logic [31:0]  PARK_ADDR = PARK_ADDR_DEFAULT,
  localparam int unsigned CW        = $clog2(MAX_BURST + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // Handshake: a port raises p_req_i and holds its we/addr/wdata stable until
  // p_gnt_o is seen; the transaction is accepted in the cycle req & gnt is high.
  input  logic [1:0]       p_req_i,
  input  logic [1:0]       p_we_i,
  input  logic [1:0][31:0] p_addr_i,
  input  logic [1:0][31:0] p_wdata_i,
  output logic [1:0]       p_gnt_o,
  output logic [1:0]       p_rvalid_o,
  output logic [1:0]       p_err_o,
  output logic [31:0]      p_rdata_o,
  output logic [31:0]      m_addr_o,
  output logic [31:0]      m_st_data_o,
  output logic             m_st_en_o,
  input  logic [31:0]      m_ld_data_i,
  output owner_e           dbg_owner_o,
  output logic             dbg_last_o,
  output logic [CW-1:0]    dbg_burst_cnt_o
);

  owner_e        owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [1:0]    err_q, err_d;

  logic [1:0] pick_gnt;
  logic [1:0] own_onehot;
  logic [1:0] accept;
  logic       own_req, other_req, burst_room, keep;
  logic       acc_any, acc_port, aligned;

  rr_pick2 u_pick (
    .req_i  (p_req_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q     <= OWN_NONE;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      rvalid_q    <= 2'b00;
      err_q       <= 2'b00;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    own_onehot  = 2'b00;
    p_gnt_o     = 2'b00;
    accept      = 2'b00;
    m_addr_o    = PARK_ADDR;
    m_st_data_o = '0;
    m_st_en_o   = 1'b0;
    owner_d     = OWN_NONE;
    last_d      = last_q;
    burst_cnt_d = '0;
    rvalid_d    = 2'b00;
    err_d       = 2'b00;

    case (owner_q)
      OWN_P0:  own_onehot = 2'b01;
      OWN_P1:  own_onehot = 2'b10;
      default: own_onehot = 2'b00;
    endcase

    own_req    = |(own_onehot & p_req_i);
    other_req  = |(~own_onehot & p_req_i);
    burst_room = burst_cnt_q < CW'(MAX_BURST);
    // The owner keeps the port until its burst is spent, unless nobody else wants it;
    // otherwise the round-robin picker (last = owner) hands it over.
    keep       = own_req && (burst_room || !other_req);

    if (!rst_i) p_gnt_o = keep ? own_onehot : pick_gnt;

    accept   = p_gnt_o & p_req_i;
    acc_any  = |accept;
    acc_port = accept[1];
    aligned  = (p_addr_i[acc_port][1:0] == 2'b00);

    if (acc_any) begin
      owner_d = acc_port ? OWN_P1 : OWN_P0;
      last_d  = acc_port;
      if (owner_q == owner_d) begin
        burst_cnt_d = burst_room ? CW'(burst_cnt_q + 1'b1) : burst_cnt_q;
      end else begin
        burst_cnt_d = CW'(1);
      end

      // Misaligned accesses never reach the LSU; they only produce an error pulse.
      if (aligned) begin
        m_addr_o    = p_addr_i[acc_port];
        m_st_data_o = p_wdata_i[acc_port];
        m_st_en_o   = p_we_i[acc_port];
        if (!p_we_i[acc_port]) rvalid_d[acc_port] = 1'b1;
      end else begin
        err_d[acc_port] = 1'b1;
      end
    end
  end

  assign p_rvalid_o      = rvalid_q;
  assign p_err_o         = err_q;
  assign p_rdata_o       = (|rvalid_q) ? m_ld_data_i : '0;
  assign dbg_owner_o     = owner_q;
  assign dbg_last_o      = last_q;
  assign dbg_burst_cnt_o = burst_cnt_q;

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Directed bench for lsu_port_arbiter: reset, single read, write pass-through,
// misaligned error, early release, reset mid-read and burst contention.
module tb_lsu_port_arbiter;
  import lsu_arb_pkg::*;

  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned CW        = $clog2(MAX_BURST + 1);

  logic             clk_i;
  logic             rst_i;
  logic [1:0]       p_req_i;
  logic [1:0]       p_we_i;
  logic [1:0][31:0] p_addr_i;
  logic [1:0][31:0] p_wdata_i;
  logic [1:0]       p_gnt_o;
  logic [1:0]       p_rvalid_o;
  logic [1:0]       p_err_o;
  logic [31:0]      p_rdata_o;
  logic [31:0]      m_addr_o;
  logic [31:0]      m_st_data_o;
  logic             m_st_en_o;
  logic [31:0]      m_ld_data_i;
  owner_e           dbg_owner_o;
  logic             dbg_last_o;
  logic [CW-1:0]    dbg_burst_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  lsu_port_arbiter #(.MAX_BURST(MAX_BURST), .PARK_ADDR(32'h0)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .p_req_i         (p_req_i),
    .p_we_i          (p_we_i),
    .p_addr_i        (p_addr_i),
    .p_wdata_i       (p_wdata_i),
    .p_gnt_o         (p_gnt_o),
    .p_rvalid_o      (p_rvalid_o),
    .p_err_o         (p_err_o),
    .p_rdata_o       (p_rdata_o),
    .m_addr_o        (m_addr_o),
    .m_st_data_o     (m_st_data_o),
    .m_st_en_o       (m_st_en_o),
    .m_ld_data_i     (m_ld_data_i),
    .dbg_owner_o     (dbg_owner_o),
    .dbg_last_o      (dbg_last_o),
    .dbg_burst_cnt_o (dbg_burst_cnt_o)
  );

  // Clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // LSU model: registered read, word at byte address a reads as 0xA500_0000 | a[7:2].
  always @(posedge clk_i) m_ld_data_i <= 32'hA500_0000 | {26'd0, m_addr_o[7:2]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    p_req_i      = req;
    p_we_i       = we;
    p_addr_i[0]  = a0;
    p_addr_i[1]  = a1;
    p_wdata_i[0] = d0;
    p_wdata_i[1] = d1;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    check("rst_gnt",    32'(p_gnt_o),     32'h0);
    check("rst_rvalid", 32'(p_rvalid_o),  32'h0);
    check("rst_err",    32'(p_err_o),     32'h0);
    check("rst_addr",   m_addr_o,         32'h0);
    check("rst_st_en",  32'(m_st_en_o),   32'h0);
    check("rst_rdata",  p_rdata_o,        32'h0);
    check("rst_owner",  32'(dbg_owner_o), 32'(OWN_NONE));
    check("rst_last",   32'(dbg_last_o),  32'h1);
    next_cycle();
    rst_i = 1'b0;

    // Single read from P0
    drive(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    check("rd_gnt",   32'(p_gnt_o),   32'h1);
    check("rd_addr",  m_addr_o,       32'h10);
    check("rd_st_en", 32'(m_st_en_o), 32'h0);
    exp_q.push_back(32'hA500_0004);
    next_cycle();
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    check("rd_rvalid", 32'(p_rvalid_o), 32'h1);
    check("rd_exp_q",  32'(exp_q.size()), 32'h1);
    if (exp_q.size() > 0) check("rd_rdata", p_rdata_o, exp_q.pop_front());

    // Write pass-through from P1 to HEX0
    next_cycle();
    drive(2'b10, 2'b10, 32'h0, IO_HEX0, 32'h0, 32'h3F);
    @(negedge clk_i);
    check("wr_gnt",   32'(p_gnt_o),   32'h2);
    check("wr_addr",  m_addr_o,       32'h800);
    check("wr_data",  m_st_data_o,    32'h3F);
    check("wr_st_en", 32'(m_st_en_o), 32'h1);
    next_cycle();
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    check("wr_st_en_off", 32'(m_st_en_o),  32'h0);
    check("wr_park",      m_addr_o,        32'h0);
    check("wr_no_rvalid", 32'(p_rvalid_o), 32'h0);

    // Misaligned read from P0
    next_cycle();
    drive(2'b01, 2'b00, 32'h13, 32'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    check("mis_gnt",   32'(p_gnt_o),   32'h1);
    check("mis_addr",  m_addr_o,       32'h0);
    check("mis_st_en", 32'(m_st_en_o), 32'h0);
    next_cycle();
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    check("mis_err",    32'(p_err_o),    32'h1);
    check("mis_rvalid", 32'(p_rvalid_o), 32'h0);
    next_cycle();
    @(negedge clk_i);
    check("mis_err_clr", 32'(p_err_o), 32'h0);

    // Early release: P0 owns with burst_cnt=2, drops req while P1 waits
    next_cycle();
    drive(2'b01, 2'b00, 32'h20, 32'h24, 32'h0, 32'h0);
    @(negedge clk_i);
    check("er_gnt0", 32'(p_gnt_o), 32'h1);
    next_cycle();
    drive(2'b11, 2'b00, 32'h20, 32'h24, 32'h0, 32'h0);
    @(negedge clk_i);
    check("er_gnt1",  32'(p_gnt_o),       32'h1);
    check("er_burst1", 32'(dbg_burst_cnt_o), 32'h1);
    next_cycle();
    drive(2'b10, 2'b00, 32'h20, 32'h24, 32'h0, 32'h0);
    @(negedge clk_i);
    check("er_gnt_p1", 32'(p_gnt_o),         32'h2);
    check("er_burst2", 32'(dbg_burst_cnt_o), 32'h2);
    check("er_own_p0", 32'(dbg_owner_o),     32'(OWN_P0));
    next_cycle();
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    check("er_burst_p1", 32'(dbg_burst_cnt_o), 32'h1);
    check("er_own_p1",   32'(dbg_owner_o),     32'(OWN_P1));
    check("er_rvalid",   32'(p_rvalid_o),      32'h2);
    check("er_rdata",    p_rdata_o,            32'hA500_0009);

    // Reset in the middle of a read
    next_cycle();
    drive(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    check("mr_gnt", 32'(p_gnt_o), 32'h1);
    rst_i = 1'b1;
    #1;
    check("mr_gnt_rst",  32'(p_gnt_o), 32'h0);
    check("mr_addr_rst", m_addr_o,     32'h0);
    next_cycle();
    check("mr_rvalid_rst", 32'(p_rvalid_o), 32'h0);
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("mr_rvalid_post", 32'(p_rvalid_o), 32'h0);
    check("mr_err_post",    32'(p_err_o),    32'h0);

    // Contention from reset: 4 x P0, 4 x P1, 4 x P0
    next_cycle();
    rst_i = 1'b1;
    drive(2'b11, 2'b00, 32'h30, 32'h34, 32'h0, 32'h0);
    #1;
    check("ct_gnt_rst", 32'(p_gnt_o), 32'h0);
    next_cycle();
    rst_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic [1:0] exp_gnt;
      exp_gnt = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
      @(negedge clk_i);
      check($sformatf("ct_gnt%0d", i), 32'(p_gnt_o), 32'(exp_gnt));
      check($sformatf("ct_onehot%0d", i), 32'($countones(p_gnt_o) <= 1), 32'h1);
      next_cycle();
    end
    drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
